// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the shared multiply/divide units of the EXE stage.
// One operation in flight; the unit result is committed to {HI,LO} or dropped on flush.
module muldiv_ctrl #(
  parameter int unsigned WATCHDOG  = 64,
  parameter logic [31:0] HILO_INIT = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  output logic        mul_start_o,
  output logic        div_start_o,
  output logic        unit_signed_o,
  output logic [31:0] unit_op1_o,
  output logic [31:0] unit_op2_o,
  input  logic        mul_done_i,
  input  logic [63:0] mul_product_i,
  input  logic        div_done_i,
  input  logic [63:0] div_result_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_busy_o,
  output logic        resp_valid_o,
  output logic        err_timeout_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 7;
  localparam logic [CW-1:0] WD_CNT  = CW'(WATCHDOG);
  localparam logic [CW-1:0] CNT_MAX = '1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic            signed_q, signed_d;
  logic            is_div_q, is_div_d;
  logic            mul_start_q, mul_start_d;
  logic            div_start_q, div_start_d;
  logic            resp_q, resp_d;
  logic            err_q, err_d;

  logic            accept;
  logic            first_run;
  logic            done_sel;
  logic            done_ok;
  logic [63:0]     res_sel;
  logic [CW-1:0]   cnt_inc;

  assign req_ready_o = (state_q == S_IDLE) & ~flush_i & ~reset_i;
  assign accept      = req_valid_i & req_ready_o;
  // The start pulse marks the first RUN cycle; a done seen there is stale.
  assign first_run   = mul_start_q | div_start_q;
  assign done_sel    = is_div_q ? div_done_i : mul_done_i;
  assign res_sel     = is_div_q ? div_result_i : mul_product_i;
  assign done_ok     = done_sel & ~first_run;
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    signed_d    = signed_q;
    is_div_d    = is_div_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    resp_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (req_op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op1_d    = req_src1_i;
              op2_d    = req_src2_i;
              signed_d = ~req_op_i[0];
              is_div_d = req_op_i[1];
              cnt_d    = '0;
              if (req_op_i[1]) begin
                state_d     = S_DIV_RUN;
                div_start_d = 1'b1;
              end else begin
                state_d     = S_MUL_RUN;
                mul_start_d = 1'b1;
              end
            end
            OP_MTHI: begin
              hi_d   = req_src1_i;
              resp_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_src1_i;
              resp_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL_RUN, S_DIV_RUN: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          state_d = done_ok ? S_IDLE : S_DRAIN;
        end else if (done_ok) begin
          {hi_d, lo_d} = res_sel;
          resp_d       = 1'b1;
          state_d      = S_IDLE;
        end else if (cnt_q == WD_CNT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Unit cannot be aborted: wait out its done, or give up at the watchdog.
        cnt_d = cnt_inc;
        if (done_sel || (cnt_q >= WD_CNT)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= HILO_INIT;
      lo_q        <= HILO_INIT;
      op1_q       <= '0;
      op2_q       <= '0;
      signed_q    <= 1'b0;
      is_div_q    <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      resp_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      signed_q    <= signed_d;
      is_div_q    <= is_div_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  assign mul_start_o   = mul_start_q;
  assign div_start_o   = div_start_q;
  assign unit_signed_o = signed_q;
  assign unit_op1_o    = op1_q;
  assign unit_op2_o    = op2_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign hilo_busy_o   = (state_q != S_IDLE);
  assign resp_valid_o  = resp_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand sequences for
// flush/reset/back-to-back corners, and random operations against an arithmetic model.
module tb_muldiv_ctrl;

  localparam int WD = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_ready;
  logic        flush;
  logic        mul_start, div_start, unit_signed;
  logic [31:0] unit_op1, unit_op2;
  logic        mul_done, div_done;
  logic [63:0] mul_product, div_result;
  logic [31:0] hi, lo;
  logic        hilo_busy, resp_valid, err_timeout;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WATCHDOG(64), .HILO_INIT(32'h0)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_src1_i(req_src1), .req_src2_i(req_src2), .req_ready_o(req_ready),
    .flush_i(flush),
    .mul_start_o(mul_start), .div_start_o(div_start), .unit_signed_o(unit_signed),
    .unit_op1_o(unit_op1), .unit_op2_o(unit_op2),
    .mul_done_i(mul_done), .mul_product_i(mul_product),
    .div_done_i(div_done), .div_result_i(div_result),
    .hi_o(hi), .lo_o(lo), .hilo_busy_o(hilo_busy),
    .resp_valid_o(resp_valid), .err_timeout_o(err_timeout)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] s1, s2;
    int          lat;       // cycles from start pulse to unit done; -1 = never
    int          flush_at;  // cycle (0 = start cycle) to pulse flush; -1 = none
    logic [63:0] ures;
    logic [31:0] exp_hi, exp_lo;
    int          exp_resp, exp_err;
  } vec_t;

  typedef struct {
    int ready, resp_cnt, resp_c, err_cnt, err_c;
    int busy_cnt, start_cnt, wrong_start, hold_bad;
  } obs_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl_hi, mdl_lo;
  vec_t        vecs[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Plain-arithmetic result a real unit would return.
  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] sp;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin sp = 64'(sa) * 64'(sb); return sp; end
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: return {32'(sa % sb), 32'(sa / sb)};
      default: return {a % b, a / b};
    endcase
  endfunction

  // Architectural outcome: commit when done arrives in [1,WD] and no flush got there first.
  task automatic outcome(input logic [2:0] op, input int lat, input int flush_at,
                         output int resp, output int err, output int run_end);
    bit discard;
    run_end = (lat >= 1 && lat <= WD) ? lat : WD;
    discard = (flush_at >= 0) && (flush_at <= run_end);
    resp = 0;
    err  = 0;
    if (op == 3'd4 || op == 3'd5) resp = 1;
    else if (op < 3'd4) begin
      if (!discard && lat >= 1 && lat <= WD) resp = 1;
      else if (!discard) err = 1;
    end
  endtask

  // Issue one request, act as both units, and record what the DUT did.
  task automatic run_op(input logic [2:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input int lat, input int flush_at, input logic [63:0] ures,
                        output obs_t o);
    int  start_c, idle_seen;
    bit  sel_div, exp_sgn, dn;
    o = '{default: 0};
    o.resp_c = -1;
    o.err_c  = -1;
    start_c  = -1;
    idle_seen = 0;
    sel_div  = (op == 3'd2) || (op == 3'd3);
    exp_sgn  = (op == 3'd0) || (op == 3'd2);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = s1;
    req_src2  = s2;
    o.ready   = int'(req_ready);
    tick();
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    for (int c = 0; c < 200; c++) begin
      if (resp_valid) begin o.resp_cnt++; if (o.resp_c < 0) o.resp_c = c; end
      if (err_timeout) begin o.err_cnt++; if (o.err_c < 0) o.err_c = c; end
      if (hilo_busy) o.busy_cnt++;
      if (mul_start || div_start) begin
        o.start_cnt++;
        if (start_c < 0) start_c = c;
        if ((sel_div && mul_start) || (!sel_div && div_start)) o.wrong_start++;
      end
      if (hilo_busy && (unit_op1 !== s1 || unit_op2 !== s2 || unit_signed !== exp_sgn))
        o.hold_bad++;
      dn = (start_c >= 0) && (lat >= 0) && (c == start_c + lat);
      mul_done    = sel_div ? 1'($urandom % 2) : dn;
      div_done    = sel_div ? dn : 1'($urandom % 2);
      mul_product = (!sel_div && dn) ? ures : {$urandom, $urandom};
      div_result  = (sel_div && dn) ? ures : {$urandom, $urandom};
      flush       = (c == flush_at);
      if (!hilo_busy && c >= 1) idle_seen++;
      if (idle_seen == 2) break;
      tick();
    end
    mul_done = 1'b0;
    div_done = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_obs(input string nm, input logic [2:0] op, input int lat,
                           input int flush_at, input obs_t o, input logic [31:0] eh,
                           input logic [31:0] el, input int er, input int ee);
    int m_resp, m_err, run_end;
    outcome(op, lat, flush_at, m_resp, m_err, run_end);
    chk({nm, " req_ready"}, 64'(o.ready), 64'd1);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " resp_cnt"}, 64'(o.resp_cnt), 64'(er));
    chk({nm, " err_cnt"}, 64'(o.err_cnt), 64'(ee));
    if (er == 1) chk({nm, " resp_cycle"}, 64'(o.resp_c), (op < 3'd4) ? 64'(lat + 1) : 64'd0);
    if (ee == 1) chk({nm, " err_cycle"}, 64'(o.err_c), 64'(WD + 1));
    if (op < 3'd4) begin
      chk({nm, " busy_cycles"}, 64'(o.busy_cnt), 64'(run_end + 1));
      chk({nm, " start_cnt"}, 64'(o.start_cnt), 64'd1);
      chk({nm, " wrong_unit"}, 64'(o.wrong_start), 64'd0);
      chk({nm, " op_hold"}, 64'(o.hold_bad), 64'd0);
    end else begin
      chk({nm, " busy_cycles"}, 64'(o.busy_cnt), 64'd0);
      chk({nm, " start_cnt"}, 64'(o.start_cnt), 64'd0);
    end
  endtask

  initial begin
    obs_t o;
    int   starts, busy_seen, er, ee, re, r;
    logic [2:0]  op;
    logic [31:0] s1, s2;
    int   lat, fa;
    logic [63:0] ures;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0;
    flush = 1'b0; mul_done = 1'b0; div_done = 1'b0; mul_product = '0; div_result = '0;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2, 3, -1, 64'hFFFFFFFF_FFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2, 3, -1, 64'h00000001_FFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 1, 0};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 33, -1, 64'hFFFFFFFF_FFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 33, 5, 64'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0};
    vecs[4]  = '{3'd4, 32'h00001234, 32'd0, -1, -1, 64'h0, 32'h00001234, 32'hFFFFFFFD, 1, 0};
    vecs[5]  = '{3'd0, 32'd5, 32'd6, -1, -1, 64'd30, 32'h00001234, 32'hFFFFFFFD, 0, 1};
    vecs[6]  = '{3'd5, 32'h0000CAFE, 32'd0, -1, -1, 64'h0, 32'h00001234, 32'h0000CAFE, 1, 0};
    vecs[7]  = '{3'd6, 32'h0000DEAD, 32'd1, -1, -1, 64'h0, 32'h00001234, 32'h0000CAFE, 0, 0};
    vecs[8]  = '{3'd3, 32'd100, 32'd0, 10, -1, 64'h00000064_FFFFFFFF, 32'h00000064, 32'hFFFFFFFF, 1, 0};
    vecs[9]  = '{3'd0, 32'd3, 32'd4, 1, -1, 64'd12, 32'h0, 32'hC, 1, 0};
    vecs[10] = '{3'd0, 32'd7, 32'd8, 0, -1, 64'd99, 32'h0, 32'hC, 0, 1};
    vecs[11] = '{3'd1, 32'd9, 32'd9, 64, -1, 64'h00000001_00000002, 32'h1, 32'h2, 1, 0};
    vecs[12] = '{3'd2, 32'd9, 32'd3, 65, -1, 64'd7, 32'h1, 32'h2, 0, 1};
    vecs[13] = '{3'd0, 32'd1, 32'd5, 7, 7, 64'd5, 32'h1, 32'h2, 0, 0};
    vecs[14] = '{3'd3, 32'd40, 32'd4, 20, 0, 64'd9, 32'h1, 32'h2, 0, 0};
    vecs[15] = '{3'd7, 32'hFFFF0000, 32'd3, -1, -1, 64'h0, 32'h1, 32'h2, 0, 0};

    // Reset, then five idle cycles.
    tick(); tick();
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    reset = 1'b0;
    starts = 0; busy_seen = 0; re = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      starts    += int'(mul_start) + int'(div_start);
      busy_seen += int'(hilo_busy);
      re        += int'(resp_valid) + int'(err_timeout);
    end
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_busy", 64'(busy_seen), 64'd0);
    chk("reset_starts", 64'(starts), 64'd0);
    chk("reset_pulses", 64'(re), 64'd0);

    // Flush in the request cycle blocks the accept.
    req_valid = 1'b1; req_op = 3'd4; req_src1 = 32'hBEEF; flush = 1'b1;
    #1;
    chk("flushreq_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flushreq_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("flushreq_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].lat, vecs[i].flush_at, vecs[i].ures, o);
      check_obs($sformatf("vec%0d", i), vecs[i].op, vecs[i].lat, vecs[i].flush_at, o,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_resp, vecs[i].exp_err);
    end

    // Back-to-back: a new request is taken in the resp_valid cycle.
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd3; req_src2 = 32'd5;
    tick();
    req_valid = 1'b0;
    chk("b2b_start", 64'(mul_start), 64'd1);
    tick();
    mul_done = 1'b1; mul_product = 64'd15;
    tick();
    mul_done = 1'b0;
    chk("b2b_resp", 64'(resp_valid), 64'd1);
    chk("b2b_lo", 64'(lo), 64'd15);
    chk("b2b_busy", 64'(hilo_busy), 64'd0);
    chk("b2b_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = 3'd5; req_src1 = 32'h55;
    tick();
    req_valid = 1'b0;
    chk("b2b_mtlo", 64'(lo), 64'h55);
    chk("b2b_resp2", 64'(resp_valid), 64'd1);
    mdl_hi = 32'h0;
    mdl_lo = 32'h55;

    // Random operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      s1 = $urandom;
      s2 = $urandom;
      if (op == 3'd2 || op == 3'd3) begin
        if (s2 == 32'h0) s2 = 32'd1;
        if (op == 3'd2 && s1 == 32'h80000000 && s2 == 32'hFFFFFFFF) s2 = 32'd2;
      end
      r = $urandom_range(0, 9);
      lat = (r == 0) ? -1 : (r == 1) ? 0 : (r == 2) ? $urandom_range(65, 70) : $urandom_range(1, 40);
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 45) : -1;
      ures = unit_calc(op, s1, s2);
      run_op(op, s1, s2, lat, fa, ures, o);
      outcome(op, lat, fa, er, ee, r);
      if (er == 1) begin
        if (op == 3'd4) mdl_hi = s1;
        else if (op == 3'd5) mdl_lo = s1;
        else {mdl_hi, mdl_lo} = ures;
      end
      check_obs($sformatf("rnd%0d", n), op, lat, fa, o, mdl_hi, mdl_lo, er, ee);
    end

    // Reset mid-RUN aborts; a late done is ignored.
    req_valid = 1'b1; req_op = 3'd0; req_src1 = 32'd2; req_src2 = 32'd2;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_busy_before", 64'(hilo_busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(hilo_busy), 64'd0);
    chk("midrst_hilo", 64'({hi, lo}), 64'd0);
    mul_done = 1'b1; mul_product = 64'hFFFF;
    tick();
    mul_done = 1'b0;
    chk("midrst_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("midrst_late_done", 64'({hi, lo}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
